// File: rtl/datapath_core.sv
// 16-bit RISC datapath: 8-entry register file, A/B operand registers, shifter on B,
// operand muxes, 4-function ALU, result register C and registered zero flag.
module datapath_core #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] datapath_in,
    input  logic              vsel,
    input  logic [2:0]        writenum,
    input  logic              write,
    input  logic [2:0]        readnum,
    input  logic              loada,
    input  logic              loadb,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [1:0]        ALUop,
    input  logic              loadc,
    input  logic              loads,
    output logic              status,
    output logic [DATA_W-1:0] datapath_out
);

    localparam int unsigned IMM_W = 5;
    localparam int unsigned NREG  = 8;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              status_q;

    logic [DATA_W-1:0] data_in_c;
    logic [DATA_W-1:0] data_out_c;
    logic [DATA_W-1:0] b_shift_c;
    logic [DATA_W-1:0] ain_c, bin_c;
    logic [DATA_W-1:0] alu_c;
    logic              zero_c;

    assign data_in_c  = vsel ? datapath_in : c_q;
    assign data_out_c = rf_q[readnum];

    // Shifter on B
    always_comb begin
        b_shift_c = b_q;
        unique case (shift)
            2'b00: b_shift_c = b_q;
            2'b01: b_shift_c = {b_q[DATA_W-2:0], 1'b0};
            2'b10: b_shift_c = {1'b0, b_q[DATA_W-1:1]};
            2'b11: b_shift_c = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
            default: b_shift_c = b_q;
        endcase
    end

    assign ain_c = asel ? '0 : a_q;
    assign bin_c = bsel ? DATA_W'(datapath_in[IMM_W-1:0]) : b_shift_c;

    always_comb begin
        alu_c = '0;
        unique case (ALUop)
            2'b00: alu_c = ain_c + bin_c;
            2'b01: alu_c = ain_c - bin_c;
            2'b10: alu_c = ain_c & bin_c;
            2'b11: alu_c = ~bin_c;
            default: alu_c = '0;
        endcase
    end

    assign zero_c = (alu_c == '0);

    // Register file; reads are combinational so same-edge loads see the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (write) begin
            rf_q[writenum] <= data_in_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 1'b0;
        end else begin
            if (loada) a_q      <= data_out_c;
            if (loadb) b_q      <= data_out_c;
            if (loadc) c_q      <= alu_c;
            if (loads) status_q <= zero_c;
        end
    end

    assign status       = status_q;
    assign datapath_out = c_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: integer-arithmetic reference model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_datapath_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada, loadb;
    logic [1:0]  shift;
    logic        asel, bsel;
    logic [1:0]  ALUop;
    logic        loadc, loads;
    logic        status;
    logic [15:0] datapath_out;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    int m_r [8];
    int m_a, m_b, m_c, m_s;

    datapath_core dut (
        .clk(clk), .rst_n(rst_n), .datapath_in(datapath_in), .vsel(vsel),
        .writenum(writenum), .write(write), .readnum(readnum),
        .loada(loada), .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel),
        .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .status(status), .datapath_out(datapath_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_a = 0; m_b = 0; m_c = 0; m_s = 0;
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model follows the spec's arithmetic, not a bit-level structure
    always @(negedge clk) begin
        if (chk_on) begin
            expect_val("cycle_out", int'(datapath_out), m_c);
            expect_val("cycle_status", int'(status), m_s);
        end
    end

    task automatic clr();
        vsel = 0; writenum = 0; write = 0; readnum = 0; loada = 0; loadb = 0;
        shift = 0; asel = 0; bsel = 0; ALUop = 0; loadc = 0; loads = 0;
        datapath_in = 0;
    endtask

    // One clock: compute next model state from pre-edge values, clock, commit
    task automatic cyc();
        int din, rd, bs, ain, bin, res;
        din = vsel ? int'(datapath_in) : m_c;
        rd  = m_r[readnum];
        case (shift)
            2'd0: bs = m_b;
            2'd1: bs = (m_b * 2) % 65536;
            2'd2: bs = m_b / 2;
            default: bs = m_b / 2 + ((m_b >= 32768) ? 32768 : 0);
        endcase
        ain = asel ? 0 : m_a;
        bin = bsel ? (int'(datapath_in) % 32) : bs;
        case (ALUop)
            2'd0: res = (ain + bin) % 65536;
            2'd1: res = (ain - bin + 65536) % 65536;
            2'd2: res = ain & bin;
            default: res = 65535 - bin;
        endcase
        @(posedge clk);
        #1;
        if (write) m_r[writenum] = din;
        if (loada) m_a = rd;
        if (loadb) m_b = rd;
        if (loadc) m_c = res;
        if (loads) m_s = (res == 0) ? 1 : 0;
    endtask

    task automatic wr_imm(input int n, input int v);
        clr(); vsel = 1; datapath_in = 16'(v); writenum = 3'(n); write = 1; cyc();
    endtask

    task automatic ld(input bit to_b, input int n);
        clr(); readnum = 3'(n); if (to_b) loadb = 1; else loada = 1; cyc();
    endtask

    task automatic op(input int sh, input bit as, input bit bs, input int alu,
                      input int imm, input bit ls);
        clr(); shift = 2'(sh); asel = as; bsel = bs; ALUop = 2'(alu);
        datapath_in = 16'(imm); loadc = 1; loads = ls; cyc();
    endtask

    initial begin
        clr();
        model_reset();
        rst_n = 0;
        #2;
        expect_val("reset_out", int'(datapath_out), 0);
        expect_val("reset_status", int'(status), 0);
        #10 rst_n = 1;
        @(posedge clk); #1;
        chk_on = 1;

        // Load and add with shift
        wr_imm(0, 3);
        wr_imm(1, 4);
        ld(0, 0);
        ld(1, 1);
        op(1, 0, 0, 0, 0, 1);
        expect_val("add_shl", int'(datapath_out), 11);
        expect_val("add_shl_status", int'(status), 0);
        clr(); vsel = 0; writenum = 2; write = 1; cyc();
        ld(1, 3);
        ld(0, 2);
        op(0, 0, 0, 0, 0, 1);
        expect_val("wb_c_r2", int'(datapath_out), 11);

        // Shifter
        wr_imm(4, 16'h8001);
        ld(1, 4);
        op(0, 1, 0, 0, 0, 1); expect_val("sh00", int'(datapath_out), 16'h8001);
        op(1, 1, 0, 0, 0, 1); expect_val("sh01", int'(datapath_out), 16'h0002);
        op(2, 1, 0, 0, 0, 1); expect_val("sh10", int'(datapath_out), 16'h4000);
        op(3, 1, 0, 0, 0, 1); expect_val("sh11", int'(datapath_out), 16'hC000);

        // ALU functions
        wr_imm(5, 16'h00F0);
        wr_imm(6, 16'h0F0F);
        ld(0, 5);
        ld(1, 6);
        op(0, 0, 0, 0, 0, 1); expect_val("alu_add", int'(datapath_out), 16'h0FFF);
        op(0, 0, 0, 1, 0, 1); expect_val("alu_sub", int'(datapath_out), 16'hF1E1);
        op(0, 0, 0, 2, 0, 1); expect_val("alu_and", int'(datapath_out), 16'h0000);
        expect_val("alu_and_z", int'(status), 1);
        op(0, 0, 0, 3, 0, 1); expect_val("alu_not", int'(datapath_out), 16'hF0F0);
        expect_val("alu_not_z", int'(status), 0);

        // Immediate path and zero flag
        op(0, 1, 1, 0, 16'hFFF5, 1); expect_val("imm", int'(datapath_out), 16'h0015);
        wr_imm(7, 5);
        ld(0, 7);
        op(0, 0, 1, 1, 5, 1); expect_val("sub_zero", int'(datapath_out), 0);
        expect_val("sub_zero_z", int'(status), 1);
        op(0, 1, 1, 0, 3, 0); expect_val("hold_out", int'(datapath_out), 3);
        expect_val("hold_status", int'(status), 1);

        // Same-cycle write and read of R3
        clr(); vsel = 1; datapath_in = 7; writenum = 3; write = 1; readnum = 3; loada = 1; cyc();
        clr(); readnum = 3; loada = 1; loadc = 1; bsel = 1; cyc();
        expect_val("old_r3", int'(datapath_out), 0);
        op(0, 0, 1, 0, 0, 0); expect_val("new_r3", int'(datapath_out), 7);
        clr(); vsel = 0; writenum = 6; readnum = 6; write = 1; loadb = 1; cyc();
        op(0, 1, 0, 0, 0, 0); expect_val("old_r6", int'(datapath_out), 16'h0F0F);
        ld(1, 6);
        op(0, 1, 0, 0, 0, 0); expect_val("r6_gets_c", int'(datapath_out), 7);

        // Mid-cycle asynchronous reset
        op(0, 1, 1, 0, 9, 0);
        #2 rst_n = 0;
        #1;
        expect_val("async_out", int'(datapath_out), 0);
        expect_val("async_status", int'(status), 0);
        model_reset();
        #1 rst_n = 1;
        ld(0, 6);
        op(0, 0, 1, 0, 0, 1); expect_val("post_reset_r6", int'(datapath_out), 0);
        ld(0, 1);
        op(0, 0, 1, 0, 0, 1); expect_val("post_reset_r1", int'(datapath_out), 0);
        expect_val("post_reset_z", int'(status), 1);

        chk_on = 0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
Register-file/ALU datapath for a simple 16-bit RISC CPU. It contains an 8x16 register file, operand registers A and B, a barrel-style shifter on B, operand muxes, a 4-function ALU, a result register C and a zero-status flag. Every control input is driven by an external FSM controller. The block has no internal sequencing.

Parameters:
DATA_W, 16, datapath width. All registers, the ALU and the shifter use this width. The immediate field is fixed at 5 bits.

Ports:
clk  in  1  clock. All state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
datapath_in  in  16  external write-back value and immediate source.
vsel  in  1  write-back select: 1 = datapath_in, 0 = C.
writenum  in  3  register-file write index.
write  in  1  register-file write enable.
readnum  in  3  register-file read index.
loada  in  1  load A from the register-file read data.
loadb  in  1  load B from the register-file read data.
shift  in  2  shifter operation applied to B.
asel  in  1  1 = Ain is 0, 0 = Ain is A.
bsel  in  1  1 = Bin is zero-extended datapath_in[4:0], 0 = Bin is the shifted B.
ALUop  in  2  ALU function.
loadc  in  1  load C from the ALU output.
loads  in  1  load status from the ALU zero flag.
status  out  1  registered zero flag.
datapath_out  out  16  contents of C.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): R0-R7, A, B, C and status all clear to 0. datapath_out=0 and status=0 while reset is held.
- Write-back data: data_in = vsel ? datapath_in : C.
- Register file write: on posedge clk, if write=1 then R[writenum] <= data_in.
- Register file read: data_out = R[readnum], combinational, no latency.
- Read of the register being written in the same cycle returns the old value. The new value is visible after the edge.
- A: on posedge, if loada=1 then A <= data_out. B: on posedge, if loadb=1 then B <= data_out. Otherwise each register holds its value.
- Loading A or B in the same cycle as a write to R[readnum] captures the pre-write value.
- Shifter (combinational on B):
  - 00: B unchanged.
  - 01: B<<1, LSB filled with 0.
  - 10: B>>1 logical, MSB filled with 0.
  - 11: B>>1 arithmetic, MSB = B[15].
- Operand muxes: Ain = asel ? 16'h0000 : A. Bin = bsel ? {11'b0, datapath_in[4:0]} : shifted B.
- ALU (combinational):
  - 00: Ain+Bin, wraps mod 2^16, carry discarded.
  - 01: Ain-Bin, two's complement, wraps.
  - 10: Ain & Bin.
  - 11: ~Bin.
- Z = (ALU result == 0).
- C: on posedge, if loadc=1 then C <= ALU result. status: on posedge, if loads=1 then status <= Z. loadc and loads are independent.
- datapath_out = C, registered. A result appears one edge after loadc.
- Path latency from register to register: R -> A/B takes 1 edge, A/B -> C takes 1 edge, C -> R (vsel=0) takes 1 edge.
- All loads and write may be asserted in the same cycle. Each register samples its pre-edge inputs.
- Unknown or X control values need no defined handling.

Test Plan:
- Reset: set state nonzero, pulse rst_n low between clock edges -> datapath_out=0 and status=0 immediately. Reading any R through A and C gives 0.
- Load and add with shift: write R0=3 and R1=4 (vsel=1). A<=R0, B<=R1. shift=01, asel=0, bsel=0, ALUop=00, loadc=1, loads=1 -> datapath_out=11, status=0. Then vsel=0, writenum=2, write=1 -> R2=11, checked by reading back via A with asel=0, B=0, add.
- Shifts: B=16'h8001. shift 00/01/10/11 with Ain=0 and add -> C = 8001 / 0002 / 4000 / C000.
- ALU ops: A=16'h00F0, B=16'h0F0F, shift=00 -> add=0FFF, sub=F1E1, and=0000 (status=1), not=F0F0.
- Immediate and zero flag: asel=1, bsel=1, datapath_in=16'hFFF5, ALUop=00 -> C=0015. A=5, Bin=5, ALUop=01 -> C=0, status=1. loads=0 on the next op leaves status unchanged.
- Simultaneous events: write R3=7 while readnum=3 and loada=1 -> A gets the old R3. The next cycle's load gets 7. write with writenum=readnum and vsel=0 stores the current C.
